// File: rtl/rx_block_lock.sv
// 64b/66b sync-header block lock: tests header windows, pulses o_slip to realign the gearbox.
// Latency 1 clock from the deciding strobed header; i_header_valid low freezes all state.
module rx_block_lock #(
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 32
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [1:0]  i_header,
  input  logic        i_header_valid,
  output logic        o_slip,
  output logic        o_block_lock,
  output logic [15:0] o_slip_count
);

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [1:0] ST_LOCK_INIT = 2'd0;
  localparam logic [1:0] ST_TEST_SH   = 2'd1;
  localparam logic [1:0] ST_SLIP_WAIT = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  sh_cnt;
  logic [INV_W-1:0]  sh_invalid_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  logic              hdr_bad;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [INV_W-1:0]  inv_nxt;
  logic              slip_hit;
  logic              win_done;

  // 2'b00 and 2'b11 have even parity; both legal sync headers have odd parity.
  assign hdr_bad = ~^i_header;

  always_comb begin
    cnt_nxt  = sh_cnt + 1'b1;
    inv_nxt  = sh_invalid_cnt + {{(INV_W-1){1'b0}}, hdr_bad};
    slip_hit = hdr_bad && (!o_block_lock || (inv_nxt == INV_W'(SH_INVALID_MAX)));
    win_done = (cnt_nxt == CNT_W'(SH_CNT_MAX));
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= ST_LOCK_INIT;
      sh_cnt         <= '0;
      sh_invalid_cnt <= '0;
      wait_cnt       <= '0;
      o_slip         <= 1'b0;
      o_block_lock   <= 1'b0;
      o_slip_count   <= '0;
    end else begin
      o_slip <= 1'b0;
      case (state)
        ST_LOCK_INIT: begin
          state          <= ST_TEST_SH;
          sh_cnt         <= '0;
          sh_invalid_cnt <= '0;
        end
        ST_TEST_SH: begin
          if (i_header_valid) begin
            if (slip_hit) begin
              // Slip outranks a window that completes on the same header.
              state          <= ST_SLIP_WAIT;
              wait_cnt       <= WAIT_W'(SLIP_WAIT);
              sh_cnt         <= '0;
              sh_invalid_cnt <= '0;
              o_slip         <= 1'b1;
              o_block_lock   <= 1'b0;
              if (o_slip_count != 16'hFFFF) begin
                o_slip_count <= o_slip_count + 16'd1;
              end
            end else if (win_done) begin
              sh_cnt         <= '0;
              sh_invalid_cnt <= '0;
              if (inv_nxt == '0) begin
                o_block_lock <= 1'b1;
              end
            end else begin
              sh_cnt         <= cnt_nxt;
              sh_invalid_cnt <= inv_nxt;
            end
          end
        end
        ST_SLIP_WAIT: begin
          if (i_header_valid) begin
            if (wait_cnt <= WAIT_W'(1)) begin
              state          <= ST_TEST_SH;
              wait_cnt       <= '0;
              sh_cnt         <= '0;
              sh_invalid_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= ST_LOCK_INIT;
        end
      endcase
    end
  end

endmodule
